uart_mem_loader: RTL
====================

// Module: uart_mem_loader
// PURPOSE
// - Successor to the nibble programmer. Converts UART receive bytes into a sequence of register-width memory writes.
// - Sits between the UART receiver and the program-memory write port. Active only while programming mode is asserted.
// - Adds: generic slice count, selectable slice order, memory-side ready handshake, overrun detection, and a wrap/done indication.
// PARAMETERS
// - UART_DATA_LENGTH      8  : bits per received UART word.
// - REGISTER_WIDTH        4  : bits per memory word. Must divide UART_DATA_LENGTH.
// - MEMORY_ADDRESS_WIDTH  4  : memory address bits. Depth = 2**MEMORY_ADDRESS_WIDTH.
// - MSB_FIRST             1  : 1 = most-significant slice written first; 0 = least-significant slice first.
// - Derived: SLICES = UART_DATA_LENGTH/REGISTER_WIDTH; SLICE_CNT_W = clog2(SLICES), minimum 1.
// PORTS
// - clk_i                  in   1                    : clock.
// - reset_i                in   1                    : asynchronous, active-high reset.
// - active_i               in   1                    : programming mode enable.
// - uart_data_i            in   UART_DATA_LENGTH     : received word. Valid with strobe.
// - data_valid_strb_i      in   1                    : one-cycle pulse, new UART word.
// - mem_ready_i            in   1                    : memory accepts the write this cycle.
// - data_o                 out  REGISTER_WIDTH       : write data.
// - addr_o                 out  MEMORY_ADDRESS_WIDTH : write address.
// - enable_write_memory_o  out  1                    : write request. A write completes when this and mem_ready_i are both high.
// - busy_o                 out  1                    : a latched word is still being written out.
// - done_o                 out  1                    : one-cycle pulse when the write to the last address (all ones) completes.
// - overrun_o              out  1                    : sticky flag, a word was dropped.
// BEHAVIOUR
// - Reset: state IDLE; byte register, slice counter and address are 0; overrun is 0.
//   All outputs are 0 during reset.
// - States: IDLE, WRITE.
// - IDLE -> WRITE: when active_i and data_valid_strb_i are both high.
//   - uart_data_i is latched into the byte register.
//   - Slice counter is cleared to 0.
//   - The first write request appears in the next cycle (latency 1).
// - WRITE outputs (combinational from registers):
//   - enable_write_memory_o = 1; addr_o = addr.
//   - data_o = slice k of the latched byte. k = SLICES-1-cnt if MSB_FIRST, else k = cnt.
// - IDLE outputs: data_o, addr_o and enable_write_memory_o are all 0.
// - Completed write (enable and mem_ready_i high):
//   - addr increments modulo depth; all-ones wraps to 0.
//   - The slice counter increments.
//   - On the last slice the FSM returns to IDLE.
//   - If the written address was all ones, done_o pulses in the following cycle.
// - mem_ready_i low in WRITE: hold data_o, addr_o and enable stable, with no state change. Stalls may be unbounded.
// - Strobe while in WRITE: the word is dropped and overrun_o is set.
//   This includes a strobe in the same cycle as the last write completing; the FSM still goes to IDLE.
// - Strobe in IDLE with active_i low: ignored, no overrun.
// - active_i low at any cycle (synchronous abort), taking priority over all other events:
//   - next state IDLE; addr, slice counter and overrun are cleared.
//   - A write already presented with mem_ready_i high in that cycle still completes at the memory.
//     Internal state is discarded regardless.
// - busy_o = (state == WRITE).
// - Async reset mid-operation: immediately returns to reset values; no partial write is retained.
// STRUCTURE
// - Shared package loader_pkg:
//   - state localparams (IDLE = 1'b0, WRITE = 1'b1);
//   - clog2 function;
//   - slice-order constants.
// - One sub-module: slice_select.
//   - Purely combinational; parametrised by width and order.
//   - Maps (byte, cnt) to data_o.
// - Top level holds the FSM, counters and flags, in a separate next-state block and register block.
// TESTING
// - Defaults, active=1, strobe with 0xA5, ready always high:
//   writes (addr0, 0xA), (addr1, 0x5) on cycles N+1 and N+2; busy is high for 2 cycles.
// - MSB_FIRST=0, same stimulus: writes (addr0, 0x5), (addr1, 0xA).
// - UART_DATA_LENGTH=8, REGISTER_WIDTH=2, byte 0x1B:
//   writes 0,1,2,3 at addr 0..3; state is IDLE after 4 accepted writes.
// - mem_ready_i held low 3 cycles on the first slice:
//   outputs stay stable through the stall, then the write completes; the address advances only on acceptance.
// - 8 bytes at 4-bit depth 16: the address wraps 15 -> 0, done_o pulses once, and the 9th byte writes at addr 0.
// - Strobe during WRITE sets overrun_o and drops the byte.
//   Dropping active_i mid-WRITE gives IDLE, addr 0 and overrun 0 the next cycle.
//   Asserting reset_i mid-WRITE gives all outputs 0 at once.

Source files
------------

// File: rtl/uart_mem_loader_pkg.sv
// Shared types and helpers for the UART-to-memory loader: FSM states,
// slice-order selectors and a constant-foldable ceil(log2) helper.
package loader_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  localparam bit ORDER_MSB_FIRST = 1'b1;
  localparam bit ORDER_LSB_FIRST = 1'b0;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_mem_loader_if.sv
// Bundles the UART receive side and the memory write port of the loader.
// The slave modport is the loader itself; master is whoever drives it.
interface uart_mem_loader_if #(
  parameter int UART_DATA_LENGTH     = 8,
  parameter int REGISTER_WIDTH       = 4,
  parameter int MEMORY_ADDRESS_WIDTH = 4
);

  logic                            active_i;
  logic [UART_DATA_LENGTH-1:0]     uart_data_i;
  logic                            data_valid_strb_i;
  logic                            mem_ready_i;
  logic [REGISTER_WIDTH-1:0]       data_o;
  logic [MEMORY_ADDRESS_WIDTH-1:0] addr_o;
  logic                            enable_write_memory_o;
  logic                            busy_o;
  logic                            done_o;
  logic                            overrun_o;

  modport slave (
    input  active_i, uart_data_i, data_valid_strb_i, mem_ready_i,
    output data_o, addr_o, enable_write_memory_o, busy_o, done_o, overrun_o
  );

  modport master (
    output active_i, uart_data_i, data_valid_strb_i, mem_ready_i,
    input  data_o, addr_o, enable_write_memory_o, busy_o, done_o, overrun_o
  );

endinterface

// File: rtl/uart_mem_loader_slice_select.sv
// Combinational slice picker: returns the register-width slice of the latched
// word selected by the slice counter, honouring the configured slice order.
module slice_select
  import loader_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int SLICE_W   = 4,
  parameter int CNT_W     = 1,
  parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
  input  logic [DATA_W-1:0]  byte_i,
  input  logic [CNT_W-1:0]   cnt_i,
  output logic [SLICE_W-1:0] slice_o
);

  localparam int SLICES = DATA_W / SLICE_W;

  int k;

  always_comb begin
    k = int'(cnt_i);
    if (MSB_FIRST == ORDER_MSB_FIRST) begin
      k = SLICES - 1 - int'(cnt_i);
    end
    slice_o = byte_i[k*SLICE_W +: SLICE_W];
  end

endmodule

// File: rtl/uart_mem_loader.sv
// Turns each received UART word into SLICES consecutive memory writes,
// with a ready handshake, sticky overrun flag and a done pulse on address wrap.
module uart_mem_loader
  import loader_pkg::*;
#(
  parameter int UART_DATA_LENGTH     = 8,
  parameter int REGISTER_WIDTH       = 4,
  parameter int MEMORY_ADDRESS_WIDTH = 4,
  parameter bit MSB_FIRST            = ORDER_MSB_FIRST
) (
  input  logic              clk_i,
  input  logic              reset_i,
  uart_mem_loader_if.slave  bus
);

  localparam int SLICES      = UART_DATA_LENGTH / REGISTER_WIDTH;
  localparam int SLICE_CNT_W = (clog2(SLICES) < 1) ? 1 : clog2(SLICES);

  state_e                          state_q, state_d;
  logic [UART_DATA_LENGTH-1:0]     byte_q, byte_d;
  logic [SLICE_CNT_W-1:0]          cnt_q, cnt_d;
  logic [MEMORY_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                            overrun_q, overrun_d;
  logic                            done_q, done_d;
  logic [REGISTER_WIDTH-1:0]       slice;

  slice_select #(
    .DATA_W    (UART_DATA_LENGTH),
    .SLICE_W   (REGISTER_WIDTH),
    .CNT_W     (SLICE_CNT_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_slice_select (
    .byte_i  (byte_q),
    .cnt_i   (cnt_q),
    .slice_o (slice)
  );

  // Dropping active_i overrides everything else; the write the memory sees
  // this cycle is still on the bus because outputs come from registers.
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    overrun_d = overrun_q;
    done_d    = 1'b0;
    if (!bus.active_i) begin
      state_d   = IDLE;
      cnt_d     = '0;
      addr_d    = '0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.data_valid_strb_i) begin
            state_d = WRITE;
            byte_d  = bus.uart_data_i;
            cnt_d   = '0;
          end
        end
        WRITE: begin
          if (bus.data_valid_strb_i) begin
            overrun_d = 1'b1;
          end
          if (bus.mem_ready_i) begin
            addr_d = addr_q + MEMORY_ADDRESS_WIDTH'(1);
            cnt_d  = cnt_q + SLICE_CNT_W'(1);
            done_d = (addr_q == '1);
            if (cnt_q == SLICE_CNT_W'(SLICES - 1)) begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      byte_q    <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      overrun_q <= overrun_d;
      done_q    <= done_d;
    end
  end

  assign bus.enable_write_memory_o = (state_q == WRITE);
  assign bus.busy_o                = (state_q == WRITE);
  assign bus.addr_o                = (state_q == WRITE) ? addr_q : '0;
  assign bus.data_o                = (state_q == WRITE) ? slice : '0;
  assign bus.done_o                = done_q;
  assign bus.overrun_o             = overrun_q;

endmodule
